rc4_prga_engine: RTL and testbench

//  Parametrised RC4 keystream/decrypt engine (PRGA phase): run after S-array init+KSA; owns S RAM while busy.
//  Per byte k: i=i+1; j=j+S[i]; swap S[i],S[j]; out[k]=S[(S[i]+S[j])]^rom[k]; write out[k] to result RAM.

---
 rtl/rc4_pkg.sv | 23 ++
 rtl/rc4_char_check.sv | 20 ++
 rtl/rc4_prga_engine.sv | 185 ++++++++++++++++++
 tb/tb_rc4_prga_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA engine: FSM state encoding and the
// printable-character bounds used by the optional plaintext check.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_I,
    ST_CAP_I,
    ST_RD_J,
    ST_CAP_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_CAP_F,
    ST_NEXT,
    ST_DONE
  } rc4_prga_state_t;

  localparam logic [7:0] CH_A  = 8'h61;
  localparam logic [7:0] CH_Z  = 8'h7A;
  localparam logic [7:0] CH_SP = 8'h20;

endpackage

// File: rtl/rc4_char_check.sv
// Plaintext acceptance test: lowercase 'a'..'z' or space. Only compiled when
// RC4_VALID_CHECK_EN is defined, since the engine instantiates it only then.
`ifdef RC4_VALID_CHECK_EN
module rc4_char_check
  import rc4_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] byte_i,
  output logic         valid_o
);

  localparam logic [W-1:0] LO = W'(CH_A);
  localparam logic [W-1:0] HI = W'(CH_Z);
  localparam logic [W-1:0] SP = W'(CH_SP);

  assign valid_o = ((byte_i >= LO) && (byte_i <= HI)) || (byte_i == SP);

endmodule
`endif

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA keystream/decrypt engine: 9-cycle-per-byte walk over a registered S RAM,
// XORing keystream with ciphertext ROM into plaintext RAM. Optional RC4_VALID_CHECK_EN.
module rc4_prga_engine
  import rc4_pkg::*;
#(
  parameter int unsigned S_AW   = 8,
  parameter int unsigned MSG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [MSG_AW:0]   msg_len,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [S_AW-1:0]   s_addr,
  output logic [S_AW-1:0]   s_wdata,
  output logic              s_wen,
  input  logic [S_AW-1:0]   s_rdata,
  output logic [MSG_AW-1:0] rom_addr,
  input  logic [S_AW-1:0]   rom_rdata,
  output logic [MSG_AW-1:0] ram_addr,
  output logic [S_AW-1:0]   ram_wdata,
  output logic              ram_wen
);

  localparam logic [S_AW-1:0]   ONE_S   = S_AW'(1);
  localparam logic [MSG_AW-1:0] ONE_K   = MSG_AW'(1);
  localparam logic [MSG_AW:0]   ONE_LEN = (MSG_AW + 1)'(1);

  rc4_prga_state_t   state_q, state_d;
  logic [S_AW-1:0]   i_q, i_d;
  logic [S_AW-1:0]   j_q, j_d;
  logic [S_AW-1:0]   si_q, si_d;
  logic [S_AW-1:0]   sj_q, sj_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [MSG_AW:0]   len_q, len_d;
  logic [S_AW-1:0]   plain_byte;

  assign plain_byte = s_rdata ^ rom_rdata;
  assign busy       = (state_q != ST_IDLE);

`ifdef RC4_VALID_CHECK_EN
  logic fail_q, fail_d;
  logic pt_valid;

  rc4_char_check #(.W(S_AW)) u_char_check (
    .byte_i  (plain_byte),
    .valid_o (pt_valid)
  );

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    k_d       = k_q;
    len_d     = len_q;
`ifdef RC4_VALID_CHECK_EN
    fail_d    = fail_q;
`endif
    done      = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wen     = 1'b0;
    rom_addr  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wen   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef RC4_VALID_CHECK_EN
          fail_d = 1'b0;
`endif
          if (msg_len != '0) begin
            i_d     = ONE_S;
            j_d     = '0;
            k_d     = '0;
            len_d   = msg_len;
            state_d = ST_RD_I;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD_I: begin
        s_addr  = i_q;
        state_d = ST_CAP_I;
      end
      ST_CAP_I: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        state_d = ST_RD_J;
      end
      ST_RD_J: begin
        s_addr  = j_q;
        state_d = ST_CAP_J;
      end
      ST_CAP_J: begin
        sj_d    = s_rdata;
        state_d = ST_WR_I;
      end
      // When i==j both writes hit one entry with the same value: identity swap.
      ST_WR_I: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wen   = 1'b1;
        state_d = ST_WR_J;
      end
      ST_WR_J: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wen   = 1'b1;
        state_d = ST_RD_F;
      end
      ST_RD_F: begin
        s_addr   = si_q + sj_q;
        rom_addr = k_q;
        state_d  = ST_CAP_F;
      end
      ST_CAP_F: begin
        ram_addr  = k_q;
        ram_wdata = plain_byte;
        ram_wen   = 1'b1;
        state_d   = ST_NEXT;
`ifdef RC4_VALID_CHECK_EN
        if (!pt_valid) begin
          ram_wen = 1'b0;
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_NEXT: begin
        if ({1'b0, k_q} == (len_q - ONE_LEN)) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + ONE_K;
          i_d     = i_q + ONE_S;
          state_d = ST_RD_I;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      k_q     <= '0;
      len_q   <= '0;
`ifdef RC4_VALID_CHECK_EN
      fail_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      k_q     <= k_d;
      len_q   <= len_d;
`ifdef RC4_VALID_CHECK_EN
      fail_q  <= fail_d;
`endif
    end
  end

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Self-checking bench for rc4_prga_engine: memory models, RC4 reference model feeding a
// scoreboard queue, table-driven runs plus hand-written reset/restart/check sequences.
module tb_rc4_prga_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [5:0] msg_len = '0;
  logic       busy, done, fail, s_wen, ram_wen;
  logic [7:0] s_addr, s_wdata, s_rdata, rom_rdata, ram_wdata;
  logic [4:0] rom_addr, ram_addr;

  rc4_prga_engine #(.S_AW(8), .MSG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .msg_len(msg_len),
    .busy(busy), .done(done), .fail(fail),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen), .s_rdata(s_rdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
  );

  always #5 clk = ~clk;

  // Memories
  logic [7:0] s_mem [256];
  logic [7:0] rom   [32];
  logic [7:0] ram   [32];
  logic       load_id = 1'b0;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_id) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
    end else if (s_wen) begin
      s_mem[s_addr] <= s_wdata;
    end
    s_rdata   <= s_mem[s_addr];
    rom_rdata <= rom[rom_addr];
    if (ram_wen) ram[ram_addr] <= ram_wdata;
  end

  // Checking
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [4:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  int  n_cyc, done_cyc, busy_cnt, wen_cnt, swen_cnt;

  always @(negedge clk) begin
    if (reset_n) begin
      if (busy)  busy_cnt++;
      if (s_wen) swen_cnt++;
      if (done)  done_cyc = cyc;
      if (ram_wen) begin
        wen_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_extra_write", {ram_addr, ram_wdata}, 64'hDEAD);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("sb_ram_addr", ram_addr, e.a);
          chk("sb_ram_data", ram_wdata, e.d);
        end
      end
    end
  end

  // RC4 reference model
  logic [7:0] m_s [256];
  bit         exp_fail;
  int         exp_bytes;

  function automatic bit printable(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  // Returns expected start-to-done latency; pushes expected writes.
  task automatic model_run(input int len, output int lat);
    logic [7:0] mi, mj, t, o;
    mi = 8'd0; mj = 8'd0;
    exp_fail = 1'b0; exp_bytes = 0;
    lat = (len == 0) ? 1 : 9 * len + 1;
    for (int k = 0; k < len; k++) begin
      mi = mi + 8'd1;
      mj = mj + m_s[mi];
      t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
      o = m_s[8'(m_s[mi] + m_s[mj])] ^ rom[k];
`ifdef RC4_VALID_CHECK_EN
      if (!printable(o)) begin
        exp_fail = 1'b1;
        lat = 9 * k + 9;
        break;
      end
`endif
      exp_q.push_back('{a: 5'(k), d: o});
      exp_bytes++;
    end
  endtask

  task automatic init_identity();
    @(negedge clk); load_id = 1'b1;
    @(negedge clk); load_id = 1'b0;
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
  endtask

  task automatic fill_rom(input logic [7:0] seed);
    for (int x = 0; x < 32; x++) rom[x] = (seed == 8'h00) ? 8'h00 : (seed ^ 8'(x * 29));
  endtask

  task automatic start_run(input int len);
    @(posedge clk); #1;
    start = 1'b1; msg_len = 6'(len);
    n_cyc = cyc; done_cyc = -1; busy_cnt = 0; wen_cnt = 0; swen_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_cyc < 0 && t < 400) begin
      @(posedge clk); t++;
    end
    if (done_cyc < 0) chk({name, "_timeout"}, 0, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_run(input string name, input int lat);
    chk({name, "_done_lat"}, done_cyc - n_cyc, lat);
    chk({name, "_busy_cycles"}, busy_cnt, lat);
    chk({name, "_ram_writes"}, wen_cnt, exp_bytes);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
    chk({name, "_fail"}, fail, exp_fail);
  endtask

  typedef struct {
    int         len;
    logic [7:0] rom_seed;
    bit         fresh_s;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat;
    vecs[0] = '{len: 1,  rom_seed: 8'h00, fresh_s: 1'b1, exp_lat: 10};
    vecs[1] = '{len: 2,  rom_seed: 8'h00, fresh_s: 1'b1, exp_lat: 19};
    vecs[2] = '{len: 0,  rom_seed: 8'h11, fresh_s: 1'b0, exp_lat: 1};
    vecs[3] = '{len: 5,  rom_seed: 8'h3C, fresh_s: 1'b0, exp_lat: 46};
    vecs[4] = '{len: 32, rom_seed: 8'h5A, fresh_s: 1'b1, exp_lat: 289};
    vecs[5] = '{len: 7,  rom_seed: 8'hA7, fresh_s: 1'b0, exp_lat: 64};

    for (int x = 0; x < 32; x++) begin rom[x] = 8'h00; ram[x] = 8'h00; end

    // Reset state
    #2 reset_n = 1'b0;
    #5;
    chk("reset_outputs", {busy, done, fail, s_wen, ram_wen, s_addr, s_wdata, rom_addr, ram_addr, ram_wdata}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Table-driven runs
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].fresh_s) init_identity();
      fill_rom(vecs[v].rom_seed);
      start_run(vecs[v].len);
      model_run(vecs[v].len, lat);
`ifndef RC4_VALID_CHECK_EN
      chk($sformatf("vec%0d_lat_table", v), lat, vecs[v].exp_lat);
`endif
      wait_done($sformatf("vec%0d", v));
      check_run($sformatf("vec%0d", v), lat);
      chk($sformatf("vec%0d_s_wen", v), swen_cnt, 2 * ((exp_fail) ? exp_bytes + 1 : exp_bytes));
      for (int x = 0; x < 256; x++) begin
        if (s_mem[x] !== m_s[x]) begin
          chk($sformatf("vec%0d_s_final[%0d]", v, x), s_mem[x], m_s[x]);
          break;
        end
      end
    end

`ifndef RC4_VALID_CHECK_EN
    // Identity S, zero ROM, two bytes: literal expectations
    init_identity();
    fill_rom(8'h00);
    start_run(2);
    model_run(2, lat);
    wait_done("lit2");
    chk("lit2_ram0", ram[0], 8'h02);
    chk("lit2_ram1", ram[1], 8'h05);
    chk("lit2_s2", s_mem[2], 8'h03);
    chk("lit2_s3", s_mem[3], 8'h02);
    chk("lit2_s1", s_mem[1], 8'h01);
`else
    // Check enabled: second byte rejected
    init_identity();
    fill_rom(8'h00);
    rom[0] = 8'h63; rom[1] = 8'h00;
    ram[1] = 8'hEE;
    start_run(2);
    model_run(2, lat);
    wait_done("chk6");
    chk("chk6_ram0", ram[0], 8'h61);
    chk("chk6_ram1_untouched", ram[1], 8'hEE);
    chk("chk6_fail", fail, 1'b1);
    chk("chk6_writes", wen_cnt, 1);
    chk("chk6_done_lat", done_cyc - n_cyc, 18);
    start_run(0);
    wait_done("chk6_clear");
    chk("chk6_fail_cleared", fail, 1'b0);
`endif

    // Reset mid-run: abort at n+5 (WR_I, before any S write), then clean restart
    init_identity();
    fill_rom(8'h00);
    start_run(3);
    while (cyc < n_cyc + 5) @(posedge clk);
    #1 chk("abort_busy_before", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, fail, s_wen, ram_wen, s_addr, s_wdata, rom_addr, ram_addr, ram_wdata}, 64'h0);
    @(negedge clk) reset_n = 1'b1;
    chk("abort_no_ram_write", wen_cnt, 0);
    init_identity();
    start_run(1);
    model_run(1, lat);
    wait_done("restart");
    check_run("restart", lat);

    // start re-pulsed mid-run with a different length: ignored
    init_identity();
    fill_rom(8'h4D);
    start_run(2);
    model_run(2, lat);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; msg_len = 6'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_done("restart_ignored");
    check_run("restart_ignored", lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
